// File: rtl/index_register_bank.sv
// Bank of NUM_REGS index registers (X, Y, ...) with load/inc/dec, N/Z flags and tri-state read port.
// Optional INDEX_WRAP_DETECT_EN adds a registered wrap pulse for inc-from-ones / dec-from-zero.
module index_register_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 2,
  parameter int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                op,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [SEL_W-1:0]          rd_sel,
  input  logic                      bus_enable,
  input  logic [WIDTH-1:0]          in,
  output logic [WIDTH-1:0]          out,
  output logic [NUM_REGS*WIDTH-1:0] reg_values,
  output logic                      flag_n,
  output logic                      flag_z,
  output logic                      flag_valid
`ifdef INDEX_WRAP_DETECT_EN
  ,
  output logic                      wrap
`endif
);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rd_val;
  logic             wr_ok;
  op_e              op_q;

  always_comb begin
    op_q   = op_e'(op);
    wr_ok  = (op_q != OP_HOLD) && (int'(wr_sel) < NUM_REGS);
    cur    = '0;
    if (int'(wr_sel) < NUM_REGS) cur = regs[wr_sel];
    case (op_q)
      OP_LOAD: result = in;
      OP_INC:  result = cur + WIDTH'(1);
      OP_DEC:  result = cur - WIDTH'(1);
      default: result = cur;
    endcase
  end

`ifdef INDEX_WRAP_DETECT_EN
  logic wrap_det;

  always_comb begin
    wrap_det = ((op_q == OP_INC) && (cur == '1)) || ((op_q == OP_DEC) && (cur == '0));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b1;
      flag_valid <= 1'b0;
`ifdef INDEX_WRAP_DETECT_EN
      wrap       <= 1'b0;
`endif
    end else begin
      flag_valid <= wr_ok;
`ifdef INDEX_WRAP_DETECT_EN
      wrap       <= wr_ok && wrap_det;
`endif
      if (wr_ok) begin
        regs[wr_sel] <= result;
        flag_n       <= result[WIDTH-1];
        flag_z       <= (result == '0);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_values[i*WIDTH +: WIDTH] = regs[i];
  end

  // Out-of-range read selects return zero rather than floating the bus.
  always_comb begin
    rd_val = '0;
    if (int'(rd_sel) < NUM_REGS) rd_val = regs[rd_sel];
  end

  assign out = bus_enable ? rd_val : 'z;

endmodule

// File: tb/tb_index_register_bank.sv
// Directed bench for index_register_bank using a 3-register bank so out-of-range selects can be exercised.
module tb_index_register_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREG  = 3;
  localparam int unsigned SW    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        op;
  logic [SW-1:0]     wr_sel;
  logic [SW-1:0]     rd_sel;
  logic              bus_enable;
  logic [WIDTH-1:0]  in;
  wire  [WIDTH-1:0]  out_bus;
  logic [NREG*WIDTH-1:0] reg_values;
  logic              flag_n;
  logic              flag_z;
  logic              flag_valid;
`ifdef INDEX_WRAP_DETECT_EN
  logic              wrap;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // A released bus reads back as all ones through these pullups.
  for (genvar g = 0; g < WIDTH; g++) begin : g_pu
    pullup (out_bus[g]);
  end

  index_register_bank #(
    .WIDTH   (WIDTH),
    .NUM_REGS(NREG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .wr_sel    (wr_sel),
    .rd_sel    (rd_sel),
    .bus_enable(bus_enable),
    .in        (in),
    .out       (out_bus),
    .reg_values(reg_values),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_valid(flag_valid)
`ifdef INDEX_WRAP_DETECT_EN
    ,
    .wrap      (wrap)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; wr_sel = '0; rd_sel = '0; bus_enable = 1'b0; in = '0;
    step();
    reset = 1'b0; bus_enable = 1'b1; rd_sel = 2'd0;
    #1;
    chk("rst_out", 32'(out_bus), 32'h00);
    chk("rst_z", 32'(flag_z), 1);
    chk("rst_n", 32'(flag_n), 0);
    chk("rst_valid", 32'(flag_valid), 0);
    chk("rst_regs", 32'(reg_values), 32'h000000);

    op = 2'b01; wr_sel = 2'd0; in = 8'h7F;
    step();
    chk("ldx_regs", 32'(reg_values), 32'h00007F);
    chk("ldx_valid", 32'(flag_valid), 1);
    chk("ldx_n", 32'(flag_n), 0);
`ifdef INDEX_WRAP_DETECT_EN
    chk("ldx_wrap", 32'(wrap), 0);
`endif
    op = 2'b10;
    step();
    chk("inx_regs", 32'(reg_values), 32'h000080);
    chk("inx_n", 32'(flag_n), 1);
    chk("inx_z", 32'(flag_z), 0);
    chk("inx_valid", 32'(flag_valid), 1);
    op = 2'b00;
    step();
    chk("hold_valid", 32'(flag_valid), 0);
    chk("hold_n", 32'(flag_n), 1);
    chk("hold_regs", 32'(reg_values), 32'h000080);

    op = 2'b11; wr_sel = 2'd1;
    step();
    chk("dey_regs", 32'(reg_values), 32'h00FF80);
    chk("dey_n", 32'(flag_n), 1);
    chk("dey_valid", 32'(flag_valid), 1);
`ifdef INDEX_WRAP_DETECT_EN
    chk("dey_wrap", 32'(wrap), 1);
`endif
    op = 2'b10;
    step();
    chk("iny_regs", 32'(reg_values), 32'h000080);
    chk("iny_z", 32'(flag_z), 1);
    chk("iny_n", 32'(flag_n), 0);
`ifdef INDEX_WRAP_DETECT_EN
    chk("iny_wrap", 32'(wrap), 1);
`endif
    op = 2'b00;
    step();
    chk("hold2_valid", 32'(flag_valid), 0);
`ifdef INDEX_WRAP_DETECT_EN
    chk("hold2_wrap", 32'(wrap), 0);
`endif

    op = 2'b01; wr_sel = 2'd0; in = 8'h10;
    step();
    in = 8'h20; rd_sel = 2'd0; bus_enable = 1'b1;
    #1;
    chk("rdw_old", 32'(out_bus), 32'h10);
    step();
    chk("rdw_new", 32'(out_bus), 32'h20);
    op = 2'b00; bus_enable = 1'b0;
    #1;
    chk("bus_off", 32'(out_bus), 32'hFF);
    bus_enable = 1'b1;

    in = 8'h05; op = 2'b01;
    step();
    op = 2'b10; reset = 1'b1;
    step();
    reset = 1'b0; op = 2'b00;
    chk("rstop_regs", 32'(reg_values), 32'h000000);
    chk("rstop_z", 32'(flag_z), 1);
    chk("rstop_valid", 32'(flag_valid), 0);
`ifdef INDEX_WRAP_DETECT_EN
    chk("rstop_wrap", 32'(wrap), 0);
`endif

    op = 2'b11; wr_sel = 2'd0;
    step();
    chk("dex0_regs", 32'(reg_values), 32'h0000FF);
    chk("dex0_n", 32'(flag_n), 1);

    op = 2'b01; wr_sel = 2'd2; in = 8'h81;
    step();
    chk("ldz_regs", 32'(reg_values), 32'h8100FF);
    op = 2'b01; wr_sel = 2'd3; in = 8'hAA;
    step();
    chk("oob_regs", 32'(reg_values), 32'h8100FF);
    chk("oob_valid", 32'(flag_valid), 0);
    chk("oob_n", 32'(flag_n), 1);
    op = 2'b00; rd_sel = 2'd3; bus_enable = 1'b1;
    #1;
    chk("oob_out", 32'(out_bus), 32'h00);
    rd_sel = 2'd2;
    #1;
    chk("rd2_out", 32'(out_bus), 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
